// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes and default bus widths.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/axi4l_hold_reg.sv
// Single-entry valid/ready holding register: accepts one beat, holds it until cleared.
module axi4l_hold_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // clear only ever arrives while full, so it never collides with a capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (in_valid && !full_q) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign data     = data_q;

endmodule

// File: rtl/axi4l_slave_wr_channel.sv
// AXI4-Lite slave write path: independent AW/W holding buffers, commit to the register
// file with a one-cycle strobe, and B response generation.
module axi4l_slave_wr_channel
    import axi4l_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    i_axi_clock,
    input  logic                    i_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   i_axi_awaddr,
    input  logic [2:0]              i_axi_awprot,
    input  logic                    i_axi_awaddr_valid,
    output logic                    o_axi_awaddr_ready,
    input  logic [DATA_WIDTH-1:0]   i_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_axi_wstrb,
    input  logic                    i_axi_wdata_valid,
    output logic                    o_axi_wdata_ready,
    output logic [1:0]              o_axi_bresp,
    output logic                    o_axi_bvalid,
    input  logic                    i_axi_bready,
    output logic [ADDR_WIDTH-1:0]   o_waddr,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic                    o_wvalid
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [W_WIDTH-1:0]    w_beat;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  commit;
    logic                  full_strb;

    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  wvalid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // protection bits carry no meaning for this register file
    logic unused_awprot;
    assign unused_awprot = ^i_axi_awprot;

    axi4l_hold_reg #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_hold (
        .clk      (i_axi_clock),
        .rst      (i_axi_areset),
        .in_data  (i_axi_awaddr),
        .in_valid (i_axi_awaddr_valid),
        .in_ready (o_axi_awaddr_ready),
        .clear    (commit),
        .full     (aw_full),
        .data     (aw_addr)
    );

    axi4l_hold_reg #(
        .WIDTH (W_WIDTH)
    ) u_w_hold (
        .clk      (i_axi_clock),
        .rst      (i_axi_areset),
        .in_data  ({i_axi_wdata, i_axi_wstrb}),
        .in_valid (i_axi_wdata_valid),
        .in_ready (o_axi_wdata_ready),
        .clear    (commit),
        .full     (w_full),
        .data     (w_beat)
    );

    assign w_data    = w_beat[W_WIDTH-1:STRB_WIDTH];
    assign w_strb    = w_beat[STRB_WIDTH-1:0];
    assign full_strb = &w_strb;
    assign commit    = aw_full && w_full && (!bvalid_q || i_axi_bready);

    // partial-strobe writes are refused outright rather than merged
    always_ff @(posedge i_axi_clock or posedge i_axi_areset) begin
        if (i_axi_areset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wvalid_q <= 1'b0;
            if (commit) begin
                bvalid_q <= 1'b1;
                if (full_strb) begin
                    wvalid_q <= 1'b1;
                    waddr_q  <= aw_addr;
                    wdata_q  <= w_data;
                    bresp_q  <= RESP_OKAY;
                end else begin
                    bresp_q  <= RESP_SLVERR;
                end
            end else if (bvalid_q && i_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign o_axi_bvalid = bvalid_q;
    assign o_axi_bresp  = bresp_q;
    assign o_wvalid     = wvalid_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;

endmodule

// File: tb/tb_axi4l_slave_wr_channel.sv
// Self-checking bench for axi4l_slave_wr_channel: transaction-level model plus directed cases.
module tb_axi4l_slave_wr_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid_in = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] rf_addr;
    logic [31:0] rf_data;
    logic        rf_wvalid;

    int passed = 0;
    int total  = 0;

    axi4l_slave_wr_channel #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .i_axi_clock        (clk),
        .i_axi_areset       (rst),
        .i_axi_awaddr       (awaddr),
        .i_axi_awprot       (awprot),
        .i_axi_awaddr_valid (awvalid),
        .o_axi_awaddr_ready (awready),
        .i_axi_wdata        (wdata),
        .i_axi_wstrb        (wstrb),
        .i_axi_wdata_valid  (wvalid_in),
        .o_axi_wdata_ready  (wready),
        .o_axi_bresp        (bresp),
        .o_axi_bvalid       (bvalid),
        .i_axi_bready       (bready),
        .o_waddr            (rf_addr),
        .o_wdata            (rf_data),
        .o_wvalid           (rf_wvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Transaction model: pending beats as queues, B response as a single pending record
    logic [31:0] m_aw_q[$];
    logic [35:0] m_w_q[$];
    logic        m_bvalid = 1'b0;
    logic [1:0]  m_bresp  = 2'b00;
    logic        m_wvalid = 1'b0;
    logic [31:0] m_waddr  = '0;
    logic [31:0] m_wdata  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_aw_q.delete();
            m_w_q.delete();
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
            m_wvalid = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            bit take_aw, take_w, done;
            logic [31:0] a;
            logic [35:0] w;
            take_aw = awvalid && (m_aw_q.size() == 0);
            take_w  = wvalid_in && (m_w_q.size() == 0);
            done    = (m_aw_q.size() > 0) && (m_w_q.size() > 0) && (!m_bvalid || bready);
            m_wvalid = 1'b0;
            if (done) begin
                a = m_aw_q.pop_front();
                w = m_w_q.pop_front();
                m_bvalid = 1'b1;
                if (w[3:0] == 4'hF) begin
                    m_wvalid = 1'b1;
                    m_waddr  = a;
                    m_wdata  = w[35:4];
                    m_bresp  = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
            end else if (m_bvalid && bready) begin
                m_bvalid = 1'b0;
            end
            if (take_aw) m_aw_q.push_back(awaddr);
            if (take_w)  m_w_q.push_back({wdata, wstrb});
        end
    end

    always @(negedge clk) begin
        check("awready", awready, m_aw_q.size() == 0);
        check("wready", wready, m_w_q.size() == 0);
        check("bvalid", bvalid, m_bvalid);
        if (m_bvalid) check("bresp", bresp, m_bresp);
        check("wvalid", rf_wvalid, m_wvalid);
        check("waddr", rf_addr, m_waddr);
        check("wdata", rf_data, m_wdata);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_aw(input logic [31:0] a);
        awaddr  = a;
        awvalid = 1'b1;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        wdata     = d;
        wstrb     = s;
        wvalid_in = 1'b1;
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_wvalid", rf_wvalid, 1'b0);
        step();

        // 2: simultaneous AW/W
        drive_aw(32'h10);
        drive_w(32'hDEADBEEF, 4'hF);
        step();
        awvalid = 1'b0; wvalid_in = 1'b0; awaddr = 32'hFFFF_FFFF; wdata = '0;
        check("t2_awready_low", awready, 1'b0);
        step();
        check("t2_wvalid", rf_wvalid, 1'b1);
        check("t2_waddr", rf_addr, 32'h10);
        check("t2_wdata", rf_data, 32'hDEADBEEF);
        check("t2_bvalid", bvalid, 1'b1);
        check("t2_bresp", bresp, 2'b00);
        step();
        check("t2_wvalid_pulse", rf_wvalid, 1'b0);
        check("t2_bvalid_clr", bvalid, 1'b0);

        // 3: W three cycles ahead of AW
        drive_w(32'h12345678, 4'hF);
        step();
        wvalid_in = 1'b0; wdata = 32'h0BAD_0BAD;
        check("t3_wready_low", wready, 1'b0);
        step(2);
        check("t3_no_write_yet", rf_wvalid, 1'b0);
        drive_aw(32'h04);
        step();
        awvalid = 1'b0;
        check("t3_no_write_at_aw", rf_wvalid, 1'b0);
        step();
        check("t3_wvalid", rf_wvalid, 1'b1);
        check("t3_waddr", rf_addr, 32'h04);
        check("t3_wdata", rf_data, 32'h12345678);
        step();

        // 4: B backpressure with a second write queued behind it
        bready = 1'b0;
        drive_aw(32'h20);
        drive_w(32'h0000_000A, 4'hF);
        step();
        drive_aw(32'h24);
        drive_w(32'h0000_000B, 4'hF);
        step();
        check("t4_first_commit", rf_data, 32'h0000_000A);
        check("t4_first_bvalid", bvalid, 1'b1);
        step();
        awvalid = 1'b0; wvalid_in = 1'b0;
        check("t4_awready_drop", awready, 1'b0);
        check("t4_wready_drop", wready, 1'b0);
        step(3);
        check("t4_b_held", bvalid, 1'b1);
        check("t4_bresp_held", bresp, 2'b00);
        check("t4_no_second_write", rf_data, 32'h0000_000A);
        bready = 1'b1;
        step();
        check("t4_second_wvalid", rf_wvalid, 1'b1);
        check("t4_second_waddr", rf_addr, 32'h24);
        check("t4_bvalid_stays", bvalid, 1'b1);
        step();
        check("t4_bvalid_clr", bvalid, 1'b0);

        // 5: partial strobe -> SLVERR, no write
        drive_aw(32'h08);
        drive_w(32'h5555_5555, 4'h3);
        step();
        awvalid = 1'b0; wvalid_in = 1'b0;
        step();
        check("t5_no_wvalid", rf_wvalid, 1'b0);
        check("t5_bvalid", bvalid, 1'b1);
        check("t5_bresp", bresp, 2'b10);
        check("t5_waddr_held", rf_addr, 32'h24);
        step();

        // 6: reset with only AW held, then W alone
        drive_aw(32'h30);
        step();
        awvalid = 1'b0;
        check("t6_aw_held", awready, 1'b0);
        #2 rst = 1'b1;
        #1 check("t6_async_awready", awready, 1'b1);
        step();
        rst = 1'b0;
        check("t6_awready", awready, 1'b1);
        drive_w(32'h77, 4'hF);
        step();
        wvalid_in = 1'b0;
        step(3);
        check("t6_wready_low", wready, 1'b0);
        check("t6_no_write", rf_wvalid, 1'b0);
        check("t6_no_bvalid", bvalid, 1'b0);
        check("t6_waddr_reset", rf_addr, 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
